// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: requester IDs and default sizing.
package fb_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_GEN  = 2'd1,
    REQ_HOST = 2'd2,
    REQ_DISP = 2'd3
  } req_id_e;

  localparam int FB_WORDS_DEF     = 24000;
  localparam int DISP_RUN_MAX_DEF = 8;

endpackage

// File: rtl/fb_rr_pick.sv
// Display-first pick with a two-way round robin between generator and host.
module fb_rr_pick
  import fb_pkg::*;
(
  input  logic    gen_req,
  input  logic    host_req,
  input  logic    disp_req,
  input  logic    rr_host,
  input  logic    disp_block,
  output req_id_e pick
);

  always_comb begin
    pick = REQ_NONE;
    if (disp_req && !disp_block)
      pick = REQ_DISP;
    else if (gen_req && host_req)
      pick = rr_host ? REQ_HOST : REQ_GEN;
    else if (gen_req)
      pick = REQ_GEN;
    else if (host_req)
      pick = REQ_HOST;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: three requesters onto one single-port RAM,
// registered RAM port, tagged read returns two cycles after the grant.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int FB_WORDS     = FB_WORDS_DEF,
  parameter int DISP_RUN_MAX = DISP_RUN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_req,
  input  logic [ADDR_W-1:0] gen_addr,
  input  logic [DATA_W-1:0] gen_data,
  output logic              gen_gnt,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              range_err
);

  localparam int                RUN_W     = $clog2(DISP_RUN_MAX + 1);
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(DISP_RUN_MAX);
  localparam logic [ADDR_W:0]   OOR_LIMIT = (ADDR_W + 1)'(FB_WORDS);

  logic [RUN_W-1:0]  run_cnt;
  logic              rr_host;
  logic              writer_pend;
  logic              disp_block;
  req_id_e           pick;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_oor;
  req_id_e           sel_rd;

  req_id_e           rd_id_p0, rd_id_p1;
  logic              oor_p0, oor_p1;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] host_hold, disp_hold;

  assign writer_pend = gen_req | host_req;
  assign disp_block  = writer_pend && (run_cnt == RUN_LIMIT);

  fb_rr_pick u_pick (
    .gen_req    (gen_req),
    .host_req   (host_req),
    .disp_req   (disp_req),
    .rr_host    (rr_host),
    .disp_block (disp_block),
    .pick       (pick)
  );

  // Grants are forced low the moment reset asserts, not at the next edge.
  assign gen_gnt  = reset && (pick == REQ_GEN);
  assign host_gnt = reset && (pick == REQ_HOST);
  assign disp_gnt = reset && (pick == REQ_DISP);

  always_comb begin
    sel_addr  = gen_addr;
    sel_wdata = gen_data;
    sel_we    = 1'b0;
    sel_rd    = REQ_NONE;
    case (pick)
      REQ_GEN: sel_we = 1'b1;
      REQ_HOST: begin
        sel_addr  = host_addr;
        sel_wdata = host_wdata;
        sel_we    = host_we;
        sel_rd    = host_we ? REQ_NONE : REQ_HOST;
      end
      REQ_DISP: begin
        sel_addr = disp_addr;
        sel_rd   = REQ_DISP;
      end
      default: ;
    endcase
  end

  assign sel_oor = ({1'b0, sel_addr} >= OOR_LIMIT);

  // Stage p0: grant -> RAM port, run counter, rr pointer, read tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      rr_host   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      range_err <= 1'b0;
      rd_id_p0  <= REQ_NONE;
      oor_p0    <= 1'b0;
    end else begin
      if (pick == REQ_DISP && writer_pend)
        run_cnt <= run_cnt + 1'b1;
      else
        run_cnt <= '0;
      if (pick == REQ_GEN || pick == REQ_HOST)
        rr_host <= ~rr_host;
      if (pick != REQ_NONE) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      ram_we    <= sel_we && !sel_oor;
      range_err <= (pick != REQ_NONE) && sel_oor;
      rd_id_p0  <= sel_rd;
      oor_p0    <= sel_oor;
    end
  end

  // Stage p1: tag aligned with the RAM's registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_id_p1  <= REQ_NONE;
      oor_p1    <= 1'b0;
      host_hold <= '0;
      disp_hold <= '0;
    end else begin
      rd_id_p1  <= rd_id_p0;
      oor_p1    <= oor_p0;
      host_hold <= host_rdata;
      disp_hold <= disp_rdata;
    end
  end

  assign ret_data    = oor_p1 ? '0 : ram_rdata;
  assign host_rvalid = (rd_id_p1 == REQ_HOST);
  assign disp_rvalid = (rd_id_p1 == REQ_DISP);
  assign host_rdata  = host_rvalid ? ret_data : host_hold;
  assign disp_rdata  = disp_rvalid ? ret_data : disp_hold;

endmodule
